memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 28, block address width.
REQ-002 SHALL have parameter BLOCK_WIDTH, default 128, cache block width.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous reset, active-high.
REQ-005 SHALL have ports icache_mem_read in 1, icache_mem_address in ADDR_WIDTH, icache_mem_readdata out BLOCK_WIDTH, icache_mem_busywait out 1: the instruction cache miss port.
REQ-006 SHALL have ports dcache_mem_read in 1, dcache_mem_write in 1, dcache_mem_address in ADDR_WIDTH, dcache_mem_writedata in BLOCK_WIDTH, dcache_mem_readdata out BLOCK_WIDTH, dcache_mem_busywait out 1: the data cache miss/writeback port.
REQ-007 SHALL have ports mem_read out 1, mem_write out 1, mem_address out ADDR_WIDTH, mem_writedata out BLOCK_WIDTH, mem_readdata in BLOCK_WIDTH, mem_busywait in 1: the single shared main-memory port.

Function
REQ-008 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, RESP.
REQ-009 SHALL treat a request as pending when icache_mem_read=1 (I) or dcache_mem_read|dcache_mem_write=1 (D).
REQ-010 IDLE: only I pending -> SERVE_I; only D pending -> SERVE_D; none -> stay IDLE.
REQ-011 IDLE with I and D both pending: SHALL grant the requester not granted last (round-robin via 1-bit last_grant).
REQ-012 On grant edge: SHALL latch address, write data, read/write kind, and update last_grant.
REQ-013 SERVE_x: SHALL drive mem_read/mem_write, mem_address, mem_writedata from latched values, registered; asserted from the cycle after the grant edge.
REQ-014 SERVE_x: SHALL set seen_busy on the first edge with mem_busywait=1.
REQ-015 SERVE_x: edge with seen_busy=1 and mem_busywait=0 SHALL capture mem_readdata into the granted requester's readdata register on reads, deassert mem_read/mem_write, and enter RESP.
REQ-016 RESP: SHALL stay exactly one cycle, then enter IDLE; seen_busy cleared.
REQ-017 icache_mem_busywait SHALL equal icache_mem_read AND NOT (state=RESP AND grant=I), combinationally; dcache_mem_busywait likewise with grant=D and dcache read|write.
REQ-018 Requester readdata outputs SHALL hold their last captured value until the next completed read for that requester.
REQ-019 DCACHE write: readdata register unchanged; completion handshake identical to read.
REQ-020 dcache_mem_read and dcache_mem_write both 1: SHALL be treated as write.
REQ-021 Requester dropping its request mid-SERVE: memory transaction SHALL still complete; captured data discarded; FSM still passes through RESP.
REQ-022 Request held through RESP: SHALL be re-arbitrated in IDLE on the next cycle; no request served twice without an IDLE cycle.
REQ-023 Minimum latency grant edge to RESP: 2 cycles plus memory busy time; an idle requester SHALL never see busywait=1.

Reset
REQ-024 RESET=1 at an edge SHALL force: state IDLE, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, both readdata registers 0, seen_busy=0, last_grant=I (D wins first tie).
REQ-025 RESET mid-SERVE SHALL abandon the transaction: no capture; mem_read/mem_write low from the cycle after the reset edge.
REQ-026 Busywait outputs during reset SHALL still follow REQ-017.

Verification
REQ-027 I-only read, addr 0x0000010, memory busy 5 cycles, returns 0xA5..A5: mem_read high 1 cycle after request; icache_mem_readdata=0xA5..A5; icache busywait low for exactly 1 cycle.
REQ-028 I and D assert in same cycle after reset: D (write, addr 0x0000020) served first; I waits, then served; no overlap of mem_read and mem_write.
REQ-029 I and D continuously re-requesting: grants alternate D,I,D,I over 4 transactions.
REQ-030 RESET asserted during SERVE_D read: next cycle mem_read=0, state IDLE, dcache_mem_readdata=0.
REQ-031 D read issued, then dcache_mem_read dropped mid-SERVE: memory completes; dcache_mem_readdata unchanged; FSM returns IDLE via RESP.

Source files
------------

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Shares one main-memory port between an instruction-cache miss port (read
// only) and a data-cache miss/writeback port (read or write). Only one memory
// transaction is in flight at a time. When both caches are waiting in IDLE,
// the one that was not granted last goes next, so neither cache can starve.
//
// Transaction flow:
//   IDLE    -> SERVE_I / SERVE_D   the address, write data and kind are latched
//                                  on the grant edge
//   SERVE_x -> RESP                after memory has raised busywait at least
//                                  once and then dropped it
//   RESP    -> IDLE                the granted cache sees busywait low here
//
// Ports:
//   CLK, RESET                 single clock, synchronous active-high reset
//   icache_mem_read/_address   instruction-cache read request
//   icache_mem_readdata        last block returned to the instruction cache
//   icache_mem_busywait        high while an I request is outstanding
//   dcache_mem_read/_write     data-cache request (read+write counts as write)
//   dcache_mem_address/_writedata
//   dcache_mem_readdata        last block returned to the data cache
//   dcache_mem_busywait        high while a D request is outstanding
//   mem_read/_write/_address/_writedata  registered request to main memory
//   mem_readdata, mem_busywait           main-memory response
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   CLK,
    input  logic                   RESET,

    input  logic                   icache_mem_read,
    input  logic [ADDR_WIDTH-1:0]  icache_mem_address,
    output logic [BLOCK_WIDTH-1:0] icache_mem_readdata,
    output logic                   icache_mem_busywait,

    input  logic                   dcache_mem_read,
    input  logic                   dcache_mem_write,
    input  logic [ADDR_WIDTH-1:0]  dcache_mem_address,
    input  logic [BLOCK_WIDTH-1:0] dcache_mem_writedata,
    output logic [BLOCK_WIDTH-1:0] dcache_mem_readdata,
    output logic                   dcache_mem_busywait,

    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [BLOCK_WIDTH-1:0] mem_writedata,
    input  logic [BLOCK_WIDTH-1:0] mem_readdata,
    input  logic                   mem_busywait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Encoding of the last-grant bit.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_e                  state_q,      state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    seen_busy_q,  seen_busy_d;
    logic                    mem_read_q,   mem_read_d;
    logic                    mem_write_q,  mem_write_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,   mem_addr_d;
    logic [BLOCK_WIDTH-1:0]  mem_wdata_q,  mem_wdata_d;
    logic [BLOCK_WIDTH-1:0]  i_rdata_q,    i_rdata_d;
    logic [BLOCK_WIDTH-1:0]  d_rdata_q,    d_rdata_d;

    logic i_pend;
    logic d_pend;
    logic pick_i;

    assign i_pend = icache_mem_read;
    assign d_pend = dcache_mem_read | dcache_mem_write;

    // I wins when it is alone, or on a tie when D was the last one served.
    assign pick_i = i_pend & (~d_pend | (last_grant_q == GRANT_D));

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        seen_busy_d  = seen_busy_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (pick_i) begin
                    state_d      = SERVE_I;
                    last_grant_d = GRANT_I;
                    mem_read_d   = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = icache_mem_address;
                end else if (d_pend) begin
                    // A simultaneous read+write from the data cache is a write.
                    state_d      = SERVE_D;
                    last_grant_d = GRANT_D;
                    mem_read_d   = ~dcache_mem_write;
                    mem_write_d  = dcache_mem_write;
                    mem_addr_d   = dcache_mem_address;
                    mem_wdata_d  = dcache_mem_writedata;
                end
            end

            SERVE_I, SERVE_D: begin
                // Memory must acknowledge with busywait before a low busywait
                // can be taken as completion; otherwise the cycle right after
                // the request would look finished.
                if (mem_busywait) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    state_d     = RESP;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    // Read data is only kept if the requester is still
                    // asking for it; an abandoned read is dropped.
                    if (mem_read_q) begin
                        if (state_q == SERVE_I && icache_mem_read)
                            i_rdata_d = mem_readdata;
                        if (state_q == SERVE_D && dcache_mem_read && !dcache_mem_write)
                            d_rdata_d = mem_readdata;
                    end
                end
            end

            RESP: begin
                state_d     = IDLE;
                seen_busy_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;     // D wins the first tie
            seen_busy_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            seen_busy_q  <= seen_busy_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_addr_q;
    assign mem_writedata = mem_wdata_q;

    assign icache_mem_readdata = i_rdata_q;
    assign dcache_mem_readdata = d_rdata_q;

    // Busywait is released only during the RESP cycle of the owning requester;
    // a cache that is not requesting never sees it high.
    assign icache_mem_busywait = icache_mem_read &
                                 ~((state_q == RESP) && (last_grant_q == GRANT_I));
    assign dcache_mem_busywait = d_pend &
                                 ~((state_q == RESP) && (last_grant_q == GRANT_D));

endmodule
